// File: rtl/transient_generator.sv
// Purpose: drives one line at its valid level; on a start edge emits a glitch burst, an invalid hold, then restores.
// Latency: the line goes invalid and o_busy rises on the edge that samples the start; o_done marks the first valid cycle.
// Backpressure: none; start edges arriving while busy are ignored. Optional TRANSIENT_GEN_REPEAT_EN gives continuous mode.
module transient_generator #(
  parameter int CNT_WIDTH      = 18,
  parameter int TICKS_PER_UNIT = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_polarity,
  input  logic [3:0] i_glitches,
  input  logic [3:0] i_glitch_len,
  input  logic [3:0] i_hold,
  output logic       o_signal,
  output logic       o_busy,
  output logic       o_done
);

  // RELOAD is the single valid cycle between back-to-back sequences in continuous mode
  typedef enum logic [1:0] {IDLE, GLITCH, HOLD, RELOAD} state_t;

  state_t                 state, state_nxt;
  logic                   r_start_d;
  logic                   start;
  logic                   pol, pol_nxt;
  logic [3:0]             glitches, glitches_nxt;
  logic [3:0]             glitch_len, glitch_len_nxt;
  logic [3:0]             hold, hold_nxt;
  logic [3:0]             hp_cnt, hp_cnt_nxt;
  logic [4:0]             hp_num, hp_num_nxt;
  logic [CNT_WIDTH-1:0]   dur_cnt, dur_nxt;
  logic                   sig_nxt, busy_nxt, done_nxt;

  assign start = i_start & ~r_start_d;

  // Invalid hold length in cycles; a zero product still holds for one cycle
  function automatic logic [CNT_WIDTH-1:0] hold_ticks(input logic [3:0] h);
    logic [CNT_WIDTH-1:0] t;
    t = CNT_WIDTH'(h) * CNT_WIDTH'(TICKS_PER_UNIT);
    return (t == '0) ? CNT_WIDTH'(1) : t;
  endfunction

  // Next-state and next-output logic; every register holds unless a branch says otherwise
  always_comb begin
    state_nxt      = state;
    pol_nxt        = pol;
    glitches_nxt   = glitches;
    glitch_len_nxt = glitch_len;
    hold_nxt       = hold;
    hp_cnt_nxt     = hp_cnt;
    hp_num_nxt     = hp_num;
    dur_nxt        = dur_cnt;
    sig_nxt        = o_signal;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        sig_nxt = i_polarity;
        if (start) begin
          pol_nxt        = i_polarity;
          glitches_nxt   = i_glitches;
          glitch_len_nxt = i_glitch_len;
          hold_nxt       = i_hold;
          hp_cnt_nxt     = 4'd0;
          hp_num_nxt     = 5'd0;
          sig_nxt        = ~i_polarity;
          if (i_glitches != 4'd0) begin
            state_nxt = GLITCH;
          end else begin
            state_nxt = HOLD;
            dur_nxt   = hold_ticks(i_hold);
          end
        end
      end

      RELOAD: begin
        hp_cnt_nxt = 4'd0;
        hp_num_nxt = 5'd0;
        sig_nxt    = ~pol;
        if (glitches != 4'd0) begin
          state_nxt = GLITCH;
        end else begin
          state_nxt = HOLD;
          dur_nxt   = hold_ticks(hold);
        end
      end

      GLITCH: begin
        if (hp_cnt == glitch_len) begin
          hp_cnt_nxt = 4'd0;
          hp_num_nxt = hp_num + 5'd1;
          if (hp_num_nxt == {glitches, 1'b0}) begin
            state_nxt = HOLD;
            sig_nxt   = ~pol;
            dur_nxt   = hold_ticks(hold);
          end else begin
            sig_nxt = ~o_signal;
          end
        end else begin
          hp_cnt_nxt = hp_cnt + 4'd1;
        end
      end

      HOLD: begin
        if (dur_cnt <= CNT_WIDTH'(1)) begin
          sig_nxt   = pol;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef TRANSIENT_GEN_REPEAT_EN
          if (i_start) begin
            pol_nxt        = i_polarity;
            glitches_nxt   = i_glitches;
            glitch_len_nxt = i_glitch_len;
            hold_nxt       = i_hold;
            state_nxt      = RELOAD;
          end
`endif
        end else begin
          dur_nxt = dur_cnt - CNT_WIDTH'(1);
          sig_nxt = ~pol;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, latched configuration, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      r_start_d  <= 1'b0;
      pol        <= 1'b0;
      glitches   <= 4'd0;
      glitch_len <= 4'd0;
      hold       <= 4'd0;
      hp_cnt     <= 4'd0;
      hp_num     <= 5'd0;
      dur_cnt    <= '0;
      o_signal   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      r_start_d  <= i_start;
      pol        <= pol_nxt;
      glitches   <= glitches_nxt;
      glitch_len <= glitch_len_nxt;
      hold       <= hold_nxt;
      hp_cnt     <= hp_cnt_nxt;
      hp_num     <= hp_num_nxt;
      dur_cnt    <= dur_nxt;
      o_signal   <= sig_nxt;
      o_busy     <= busy_nxt;
      o_done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_transient_generator.sv
// Bench for transient_generator with a 4-cycle hold unit.
// Expected per-cycle {signal, busy, done} triples are queued at start and popped each cycle.
// Hand-computed sequence lengths in the vector table cross-check the queued waveforms.
module tb_transient_generator;

  localparam int TPU = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_polarity;
  logic [3:0] i_glitches;
  logic [3:0] i_glitch_len;
  logic [3:0] i_hold;
  logic       o_signal;
  logic       o_busy;
  logic       o_done;

  transient_generator #(.CNT_WIDTH(18), .TICKS_PER_UNIT(TPU)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_polarity  (i_polarity),
    .i_glitches  (i_glitches),
    .i_glitch_len(i_glitch_len),
    .i_hold      (i_hold),
    .o_signal    (o_signal),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic sig;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    logic       pol;
    logic [3:0] g;
    logic [3:0] l;
    logic [3:0] h;
    int         exp_len;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_seen;
  int   done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic obs_t cur();
    obs_t o;
    o.sig  = o_signal;
    o.busy = o_busy;
    o.done = o_done;
    return o;
  endfunction

  // Waveform model: G pairs of (L+1) invalid / (L+1) valid cycles, hold, then one valid done cycle
  task automatic push_expected(input logic p, input logic [3:0] g, input logic [3:0] l, input logic [3:0] h);
    int n;
    for (int i = 0; i < int'(g); i++) begin
      for (int j = 0; j <= int'(l); j++) exp_q.push_back({~p, 1'b1, 1'b0});
      for (int j = 0; j <= int'(l); j++) exp_q.push_back({p, 1'b1, 1'b0});
    end
    n = int'(h) * TPU;
    if (n == 0) n = 1;
    for (int i = 0; i < n; i++) exp_q.push_back({~p, 1'b1, 1'b0});
    exp_q.push_back({p, 1'b0, 1'b1});
  endtask

  // Called at a negedge: present inputs with a rising start and queue the expected response
  task automatic start_seq(input logic p, input logic [3:0] g, input logic [3:0] l, input logic [3:0] h);
    i_polarity   = p;
    i_glitches   = g;
    i_glitch_len = l;
    i_hold       = h;
    i_start      = 1'b1;
    push_expected(p, g, l, h);
    busy_seen = 0;
    done_seen = 0;
  endtask

  // mode 0: drop start; 1: toggle start/polarity mid-sequence; 2: keep start level
  task automatic drain(input int n, input int mode);
    obs_t act, e;
    int   k;
    k = 0;
    while (k < n && exp_q.size() > 0) begin
      @(negedge i_clk);
      k++;
      act = cur();
      e   = exp_q.pop_front();
      chk($sformatf("seq_cycle%0d", k), 32'(act), 32'(e));
      if (act.busy) busy_seen++;
      if (act.done) done_seen++;
      case (mode)
        0: i_start = 1'b0;
        1: begin
          i_start    = (k == 2 || k == 3 || k == 5);
          i_polarity = (k < 6) ? ~i_polarity : 1'b0;
          i_glitches   = 4'(k);
          i_hold       = 4'd9;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge i_clk);
    chk(name, 32'(cur()), 32'({i_polarity, 1'b0, 1'b0}));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{pol:1'b1, g:4'd0,  l:4'd0,  h:4'd3,  exp_len:12};
    vecs[1] = '{pol:1'b0, g:4'd2,  l:4'd1,  h:4'd0,  exp_len:9};
    vecs[2] = '{pol:1'b1, g:4'd1,  l:4'd0,  h:4'd1,  exp_len:6};
    vecs[3] = '{pol:1'b0, g:4'd3,  l:4'd2,  h:4'd2,  exp_len:26};
    vecs[4] = '{pol:1'b1, g:4'd15, l:4'd0,  h:4'd0,  exp_len:31};
    vecs[5] = '{pol:1'b0, g:4'd1,  l:4'd15, h:4'd0,  exp_len:33};
    vecs[6] = '{pol:1'b1, g:4'd0,  l:4'd0,  h:4'd15, exp_len:60};
    vecs[7] = '{pol:1'b0, g:4'd15, l:4'd15, h:4'd15, exp_len:540};

    i_rst_n = 1'b0; i_start = 1'b0; i_polarity = 1'b1;
    i_glitches = 4'd0; i_glitch_len = 4'd0; i_hold = 4'd0;
    #1;
    chk("reset_outputs", 32'(cur()), 32'(3'b000));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_idle("idle_after_release");

    // Mid-clock reset clears outputs immediately
    i_rst_n = 1'b0;
    #1;
    chk("midclk_reset", 32'(cur()), 32'(3'b000));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_idle("idle_after_second_release");

    for (int v = 0; v < 8; v++) begin
      @(negedge i_clk);
      start_seq(vecs[v].pol, vecs[v].g, vecs[v].l, vecs[v].h);
      drain(2000, 0);
      chk($sformatf("vec%0d_busy_len", v), 32'(busy_seen), 32'(vecs[v].exp_len));
      chk($sformatf("vec%0d_done_count", v), 32'(done_seen), 32'd1);
      check_idle($sformatf("vec%0d_idle", v));
    end

    // Start toggles and input changes while busy have no effect
    @(negedge i_clk);
    start_seq(1'b0, 4'd2, 4'd1, 4'd0);
    drain(2000, 1);
    chk("ignore_busy_len", 32'(busy_seen), 32'd9);
    chk("ignore_busy_done_count", 32'(done_seen), 32'd1);
    check_idle("ignore_busy_idle");

    // Start sampled in the done cycle is accepted
    @(negedge i_clk);
    start_seq(1'b1, 4'd0, 4'd0, 4'd1);
    drain(2000, 0);
    chk("b2b_first_len", 32'(busy_seen), 32'd4);
    start_seq(1'b0, 4'd1, 4'd0, 4'd0);
    drain(2000, 0);
    chk("b2b_second_len", 32'(busy_seen), 32'd3);
    check_idle("b2b_idle");

    // Reset mid-sequence aborts without a done pulse; next start runs fully
    @(negedge i_clk);
    start_seq(1'b0, 4'd2, 4'd1, 4'd0);
    drain(5, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'(cur()), 32'(3'b000));
    exp_q.delete();
    #1 i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chk($sformatf("abort_quiet%0d", c), 32'(cur()), 32'(3'b000));
    end
    start_seq(1'b0, 4'd2, 4'd1, 4'd0);
    drain(2000, 0);
    chk("after_abort_len", 32'(busy_seen), 32'd9);
    chk("after_abort_done", 32'(done_seen), 32'd1);
    check_idle("after_abort_idle");

`ifdef TRANSIENT_GEN_REPEAT_EN
    // Continuous mode: 4 invalid + 1 valid per period, busy stays high until start drops
    @(negedge i_clk);
    i_polarity = 1'b1; i_glitches = 4'd0; i_glitch_len = 4'd0; i_hold = 4'd1;
    i_start = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) exp_q.push_back({1'b0, 1'b1, 1'b0});
      exp_q.push_back({1'b1, (p < 3) ? 1'b1 : 1'b0, 1'b1});
    end
    busy_seen = 0; done_seen = 0;
    drain(16, 2);
    i_start = 1'b0;
    drain(2000, 0);
    chk("repeat_busy_len", 32'(busy_seen), 32'd19);
    chk("repeat_done_count", 32'(done_seen), 32'd4);
    check_idle("repeat_idle");
`else
    // Start held high through completion does not retrigger
    @(negedge i_clk);
    start_seq(1'b1, 4'd0, 4'd0, 4'd1);
    drain(2000, 2);
    chk("held_start_len", 32'(busy_seen), 32'd4);
    check_idle("held_start_idle0");
    check_idle("held_start_idle1");
    i_start = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/transient_generator.md
# transient_generator

- Stimulus source for the state monitor: drives a single digital line that rests at its valid level.
- On command, it emits a programmable burst of glitches, then holds the line at the invalid level for a programmable time, then restores the valid level.
- Used on-chip and on the bench to exercise transient detection and delay settings from the driving side.

## Interface

Parameters:
- CNT_WIDTH, 18, width of the duration counter; must hold 15*TICKS_PER_UNIT
- TICKS_PER_UNIT, 10000, clock cycles per hold unit (1 s at the 10 kHz system clock)

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  reset; asynchronous assert, active-low
- i_start  input  1  trigger; a rising edge starts a sequence
- i_polarity  input  1  valid level of o_signal (1 = valid high, 0 = valid low)
- i_glitches  input  4  number of glitch pulses G (0..15)
- i_glitch_len  input  4  glitch half-period minus one, L (half-period = L+1 cycles)
- i_hold  input  4  invalid hold length H, in TICKS_PER_UNIT units
- o_signal  output  1  generated line
- o_busy  output  1  high while a sequence is in progress
- o_done  output  1  one-cycle pulse when a sequence completes

## Operation

- Edge detect: r_start_d is a registered copy of i_start. A start is the condition i_start & ~r_start_d sampled at a clock edge.
- States:
  - IDLE: o_signal <= i_polarity every cycle.
    - On start, latch polarity P, G, L and H.
    - If G != 0, go to GLITCH; otherwise go to HOLD with counter = max(1, H*TICKS_PER_UNIT).
    - In both cases o_signal <= ~P.
  - GLITCH: o_signal toggles every L+1 cycles, starting at ~P. After 2*G half-periods, go to HOLD with o_signal <= ~P. The phase sequence is: invalid, valid, repeated G times.
  - HOLD: o_signal = ~P for max(1, H*TICKS_PER_UNIT) cycles. Then o_signal <= P, state <= IDLE, and o_done <= 1 for exactly one cycle.
- Arithmetic:
  - H*TICKS_PER_UNIT is computed at CNT_WIDTH bits and is unsigned.
  - The half-period counter is 4 bits and the half-period count is 5 bits (max 30).
- o_busy = (state != IDLE), registered.
- Start edges while busy are ignored. r_start_d keeps tracking i_start, so a level held high through completion does not retrigger; repeat behaviour is covered under Configuration.
- Changes to i_polarity, i_glitches, i_glitch_len or i_hold while busy have no effect until the next start.

## Timing

- Reset (async): state IDLE, o_signal 0, o_busy 0, o_done 0, r_start_d 0, counters 0.
  - First clock after release: o_signal = i_polarity.
- Start latency: o_signal goes invalid and o_busy rises on the same edge that samples the start.
- Total sequence length, from the first invalid cycle to the first restored valid cycle: 2*G*(L+1) + max(1, H*TICKS_PER_UNIT) cycles.
- o_done is asserted in the first cycle that o_signal is valid again. o_busy is low in that same cycle.
- A start sampled in the o_done cycle is accepted, because the state is already IDLE.
- Reset mid-sequence aborts immediately; no o_done is produced.

## Configuration

- TRANSIENT_GEN_REPEAT_EN defined:
  - At the end of HOLD, if i_start is still 1, the block re-latches the inputs and restarts directly.
  - o_done still pulses for that cycle and o_signal is valid for exactly that one cycle.
  - o_busy stays high through the restart.
  - This gives continuous mode.
- TRANSIENT_GEN_REPEAT_EN undefined: one sequence per rising edge of i_start.

## Test plan

- Reset/idle: TICKS_PER_UNIT=4; assert i_rst_n=0 mid-clock.
  - Outputs go to 0 immediately.
  - After release with i_polarity=1, o_signal=1 from the next edge.
- Hold only: P=1, G=0, H=3, start pulse.
  - o_signal=0 for 12 cycles, then 1.
  - o_busy high for 12 cycles; o_done one cycle with o_signal=1.
- Glitch burst: P=0, G=2, L=1, H=0.
  - o_signal pattern 1,1,0,0,1,1,0,0 then 1 for 1 cycle (HOLD min), then 0 with o_done.
  - Total 9 busy cycles.
- Ignore while busy: during the case-2 sequence, toggle i_start and flip i_polarity.
  - Sequence length and levels are unchanged.
  - o_done occurs exactly once.
- Abort: pulse i_rst_n low at cycle 5 of case 2.
  - o_signal=0, o_busy=0 at once; no o_done.
  - Next start runs a full sequence.
- Repeat (macro defined): hold i_start=1, G=0, H=1.
  - Period of 5 cycles: 4 invalid then 1 valid with o_done.
  - o_busy constant 1 until i_start drops.
